// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared serial system bus.
// Holds a grant until tx_done, request abort, or hold-counter timeout,
// then forces a one-cycle RELEASE gap before re-arbitrating.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_request,
  input  logic m2_request,
  input  logic tx_done,
  output logic m1_grant,
  output logic m2_grant,
  output logic master_sel,
  output logic bus_busy,
  output logic timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT_M1,
    S_GRANT_M2,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_owner_q, last_owner_d;  // 0 = master 1, 1 = master 2
  logic          m1_grant_q, m1_grant_d;
  logic          m2_grant_q, m2_grant_d;
  logic          master_sel_q, master_sel_d;
  logic          bus_busy_q, bus_busy_d;
  logic          timeout_err_q, timeout_err_d;

  // State and registered outputs; reset favours master 1 at the next contention
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      last_owner_q  <= 1'b1;
      m1_grant_q    <= 1'b0;
      m2_grant_q    <= 1'b0;
      master_sel_q  <= 1'b0;
      bus_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_owner_q  <= last_owner_d;
      m1_grant_q    <= m1_grant_d;
      m2_grant_q    <= m2_grant_d;
      master_sel_q  <= master_sel_d;
      bus_busy_q    <= bus_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state, arbitration, hold counter and output computation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_owner_d  = last_owner_q;
    m1_grant_d    = m1_grant_q;
    m2_grant_d    = m2_grant_q;
    master_sel_d  = master_sel_q;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE, S_RELEASE: begin
        m1_grant_d = 1'b0;
        m2_grant_d = 1'b0;
        cnt_d      = '0;
        if (m1_request && (!m2_request || last_owner_q)) begin
          state_d      = S_GRANT_M1;
          m1_grant_d   = 1'b1;
          master_sel_d = 1'b0;
        end else if (m2_request) begin
          state_d      = S_GRANT_M2;
          m2_grant_d   = 1'b1;
          master_sel_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GRANT_M1: begin
        if (tx_done || !m1_request || (cnt_q == CNT_LAST)) begin
          state_d       = S_RELEASE;
          m1_grant_d    = 1'b0;
          cnt_d         = '0;
          last_owner_d  = 1'b0;
          // Completion and abort outrank the timeout
          timeout_err_d = !tx_done && m1_request;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GRANT_M2: begin
        if (tx_done || !m2_request || (cnt_q == CNT_LAST)) begin
          state_d       = S_RELEASE;
          m2_grant_d    = 1'b0;
          cnt_d         = '0;
          last_owner_d  = 1'b1;
          timeout_err_d = !tx_done && m2_request;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        m1_grant_d = 1'b0;
        m2_grant_d = 1'b0;
        cnt_d      = '0;
      end
    endcase

    bus_busy_d = m1_grant_d | m2_grant_d;
  end

  assign m1_grant    = m1_grant_q;
  assign m2_grant    = m2_grant_q;
  assign master_sel  = master_sel_q;
  assign bus_busy    = bus_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
